// File: rtl/lstm_bptt_buffer.sv
// lstm_bptt_buffer
//   Sequencer and history store for one LSTM cell. It steps the cell through a
//   forward sequence of up to DEPTH timesteps and captures each timestep's gate
//   activations and cell state. It then replays the timesteps newest-to-oldest
//   to the BPTT gradient stage over a valid/ready port.
//
//   Optional feature macro: LSTM_BUF_HPREV_EN
//     defined   -> h(t-1) is stored per entry and driven on o_rd_h_prev
//     undefined -> no h(t-1) storage; o_rd_h_prev is tied to 0
//
// Ports
//   clk, rst                  clock, synchronous active-high reset
//   i_start, i_len            begin a forward sequence (IDLE only), its length
//   i_a..i_h                  cell outputs for the current timestep
//   o_sel, o_x_idx, o_fwd     cell control: first-step select, x index, forward active
//   o_fwd_done                one-cycle pulse once the sequence is captured
//   i_bwd_start               begin the reverse replay (READY only)
//   o_rd_valid, i_rd_ready    replay handshake
//   o_rd_t, o_rd_last         timestep of the presented entry, entry is t = 0
//   o_rd_a..o_rd_h_prev       stored words for the presented timestep
//   o_bwd_done                one-cycle pulse after the t = 0 entry is accepted
//   o_err                     one-cycle pulse on i_start with i_len = 0
//
// state  | meaning
// IDLE   | waiting for i_start
// FWD    | one timestep per clock, capturing the cell outputs
// READY  | sequence captured, waiting for i_bwd_start
// BWD    | replaying entries len-1 down to 0

module lstm_bptt_buffer #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic [AW:0]      i_len,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_i,
  input  logic [WIDTH-1:0] i_f,
  input  logic [WIDTH-1:0] i_o,
  input  logic [WIDTH-1:0] i_c,
  input  logic [WIDTH-1:0] i_h,
  output logic             o_sel,
  output logic [AW-1:0]    o_x_idx,
  output logic             o_fwd,
  output logic             o_fwd_done,
  input  logic             i_bwd_start,
  output logic             o_rd_valid,
  input  logic             i_rd_ready,
  output logic [AW-1:0]    o_rd_t,
  output logic             o_rd_last,
  output logic [WIDTH-1:0] o_rd_a,
  output logic [WIDTH-1:0] o_rd_i,
  output logic [WIDTH-1:0] o_rd_f,
  output logic [WIDTH-1:0] o_rd_o,
  output logic [WIDTH-1:0] o_rd_c,
  output logic [WIDTH-1:0] o_rd_h,
  output logic [WIDTH-1:0] o_rd_c_prev,
  output logic [WIDTH-1:0] o_rd_h_prev,
  output logic             o_bwd_done,
  output logic             o_err
);

`ifdef LSTM_BUF_HPREV_EN
  localparam int NW = 8;
`else
  localparam int NW = 7;
`endif
  localparam int EW = NW * WIDTH;
  localparam logic [AW:0] ONE     = (AW+1)'(1);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_FWD, S_READY, S_BWD} state_e;

  state_e            state_q;
  logic [AW:0]       len_q, len_d;
  logic [AW-1:0]     x_idx_q, rd_ptr_q, rd_t_q;
  logic              sel_q, fwd_q, fwd_done_q, err_q, bwd_done_q;
  logic              rd_valid_q, rd_last_q, more_q;
  logic [WIDTH-1:0]  c_prev_q;
`ifdef LSTM_BUF_HPREV_EN
  logic [WIDTH-1:0]  h_prev_q;
`endif

  logic [EW-1:0]     mem [DEPTH];
  logic [EW-1:0]     wr_word, rd_word_q;
  logic              wr_en, rd_load, rd_xfer;

  assign len_d = (i_len > DEPTH_L) ? DEPTH_L : i_len;

`ifdef LSTM_BUF_HPREV_EN
  assign wr_word = {i_a, i_i, i_f, i_o, i_c, i_h, c_prev_q, h_prev_q};
`else
  assign wr_word = {i_a, i_i, i_f, i_o, i_c, i_h, c_prev_q};
`endif

  assign wr_en   = (state_q == S_FWD) && !rst;
  assign rd_xfer = rd_valid_q && i_rd_ready;
  // The read register doubles as the output register, so the next entry is
  // fetched whenever the output slot is empty or is being drained this cycle.
  assign rd_load = (state_q == S_BWD) && more_q && (!rd_valid_q || i_rd_ready);

  always_ff @(posedge clk) begin
    if (wr_en) mem[x_idx_q] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst)          rd_word_q <= '0;
    else if (rd_load) rd_word_q <= mem[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      x_idx_q    <= '0;
      rd_ptr_q   <= '0;
      rd_t_q     <= '0;
      sel_q      <= 1'b0;
      fwd_q      <= 1'b0;
      fwd_done_q <= 1'b0;
      err_q      <= 1'b0;
      bwd_done_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      more_q     <= 1'b0;
      c_prev_q   <= '0;
`ifdef LSTM_BUF_HPREV_EN
      h_prev_q   <= '0;
`endif
    end else begin
      fwd_done_q <= 1'b0;
      err_q      <= 1'b0;
      bwd_done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            if (i_len == '0) begin
              err_q <= 1'b1;
            end else begin
              len_q    <= len_d;
              x_idx_q  <= '0;
              sel_q    <= 1'b0;
              fwd_q    <= 1'b1;
              c_prev_q <= '0;
`ifdef LSTM_BUF_HPREV_EN
              h_prev_q <= '0;
`endif
              state_q  <= S_FWD;
            end
          end
        end
        S_FWD: begin
          c_prev_q <= i_c;
`ifdef LSTM_BUF_HPREV_EN
          h_prev_q <= i_h;
`endif
          if ({1'b0, x_idx_q} == len_q - ONE) begin
            state_q    <= S_READY;
            fwd_q      <= 1'b0;
            sel_q      <= 1'b0;
            x_idx_q    <= '0;
            fwd_done_q <= 1'b1;
          end else begin
            x_idx_q <= x_idx_q + AW'(1);
            sel_q   <= 1'b1;
          end
        end
        S_READY: begin
          if (i_bwd_start) begin
            rd_ptr_q <= AW'(len_q - ONE);
            more_q   <= 1'b1;
            state_q  <= S_BWD;
          end
        end
        S_BWD: begin
          if (rd_load) begin
            rd_valid_q <= 1'b1;
            rd_t_q     <= rd_ptr_q;
            rd_last_q  <= (rd_ptr_q == '0);
            if (rd_ptr_q == '0) more_q   <= 1'b0;
            else                rd_ptr_q <= rd_ptr_q - AW'(1);
          end else if (rd_xfer) begin
            rd_valid_q <= 1'b0;
            if (rd_last_q) begin
              rd_last_q  <= 1'b0;
              bwd_done_q <= 1'b1;
              state_q    <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign o_sel       = sel_q;
  assign o_x_idx     = x_idx_q;
  assign o_fwd       = fwd_q;
  assign o_fwd_done  = fwd_done_q;
  assign o_err       = err_q;
  assign o_bwd_done  = bwd_done_q;
  assign o_rd_valid  = rd_valid_q;
  assign o_rd_t      = rd_t_q;
  assign o_rd_last   = rd_last_q;
  assign o_rd_a      = rd_word_q[EW-1           -: WIDTH];
  assign o_rd_i      = rd_word_q[EW-1 -   WIDTH -: WIDTH];
  assign o_rd_f      = rd_word_q[EW-1 - 2*WIDTH -: WIDTH];
  assign o_rd_o      = rd_word_q[EW-1 - 3*WIDTH -: WIDTH];
  assign o_rd_c      = rd_word_q[EW-1 - 4*WIDTH -: WIDTH];
  assign o_rd_h      = rd_word_q[EW-1 - 5*WIDTH -: WIDTH];
  assign o_rd_c_prev = rd_word_q[EW-1 - 6*WIDTH -: WIDTH];
`ifdef LSTM_BUF_HPREV_EN
  assign o_rd_h_prev = rd_word_q[WIDTH-1:0];
`else
  assign o_rd_h_prev = '0;
`endif

endmodule
